mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and select controller for the shared 4:1 multiplexer. Four requesters compete for one downstream channel. The block grants one requester at a time, drives the mux select pair (S1,S0) from its registered grant, and forwards the granted requester's data through a valid/ready handshake. Each grant is bounded by a burst limit, so one requester cannot starve the others.

## Interface
- WIDTH, 8, data width per requester
- MAX_BURST, 4, max accepted beats per grant (1..255)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  4  request per requester, held high while it has data
- data_in  in  4*WIDTH  requester i data at [i*WIDTH +: WIDTH]
- lock  in  4  burst-limit override per requester (only with MUX4_ARB_LOCK_EN)
- gnt  out  4  registered one-hot grant, all-zero when idle
- sel  out  2  registered mux select; sel[1]=S1, sel[0]=S0
- y_data  out  WIDTH  data_in slice selected by sel (combinational 4:1 mux)
- y_valid  out  1  |(gnt & req)
- y_ready  in  1  downstream accept
- busy  out  1  state==GRANT

## Operation
- FSM states: IDLE, GRANT. Registers: state, gnt, sel, ptr[1:0] (highest-priority index), beat_cnt[7:0].
- Arbitration order: ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first requester with req high wins.
- IDLE: gnt=0, beat_cnt=0. If req!=0 at the edge, load the winner into gnt/sel and go to GRANT.
- GRANT (owner i): a beat is accepted when y_valid && y_ready, and each accepted beat increments beat_cnt.
- Release at the edge where either condition holds:
  - req[i]==0, or
  - an accepted beat brings beat_cnt to MAX_BURST.
- On release:
  - ptr <= i+1 mod 4; beat_cnt <= 0.
  - Re-arbitrate in the same edge using the new ptr and the current req with req[i] masked.
  - If any other requester wins, grant it next cycle with no idle gap.
  - If no other requester wins but req[i] is still high (burst-limit release), regrant i.
  - If no requester remains, go to IDLE.
- sel always equals the encoded gnt; sel holds its last value in IDLE (0 after reset).
- y_data = data_in[sel*WIDTH +: WIDTH] at all times. Downstream must qualify it with y_valid.
- Output reset values: gnt=0, sel=0, busy=0, y_valid=0. Internal reset values: ptr=0, beat_cnt=0, state=IDLE.
- A reset asserted mid-burst aborts the grant immediately. No beat is completed after rst_n falls.

## Timing
- Request-to-grant latency, from IDLE: req rises before edge N, so gnt/sel are valid after edge N and y_valid is high in cycle N+1.
- Switch between owners: zero idle cycles. The last beat of owner A and the first beat of owner B are on consecutive cycles.
- Maximum throughput is one beat per cycle while y_ready=1.
- Withdrawal: a requester that drops req drops y_valid combinationally in the same cycle. Its grant clears at the next edge.
- Simultaneous events:
  - Burst-limit beat accepted and req[i] falling in the same cycle is a single release. ptr advances once.
- Backpressure: while y_ready=0, beat_cnt holds, grant holds, and y_data stays stable as long as the requester holds its data.
- rst_n is asynchronous assert. Deassertion is expected to be synchronized externally to clk.

## Configuration
- MUX4_ARB_LOCK_EN defined:
  - The lock port exists.
  - While the owner holds lock[i]=1, the burst limit is ignored (beat_cnt saturates at 255) and release happens only on req[i] falling.
  - lock of non-owners has no effect.
- Not defined:
  - No lock port.
  - The MAX_BURST release is always enforced.

## Test plan
- Reset, no requests: gnt=0, sel=0, y_valid=0, busy=0 for 10 cycles.
- Single requester: req=4'b0100, y_ready=1, data_in slice 2=8'hA5.
  - gnt=4'b0100 and sel=2'b10 one cycle later; y_data=8'hA5.
  - After 4 beats, regranted to 2 with no gap.
- All four requesting, y_ready=1, MAX_BURST=4: grants rotate 0,1,2,3,0, each for exactly 4 beats with no idle cycle between grants.
- Backpressure: owner 1, y_ready=0 for 5 cycles mid-burst. gnt holds, beat_cnt holds, and exactly 4 beats are accepted in total before the switch.
- Withdrawal and reset:
  - Owner 3 drops req after 2 beats. y_valid=0 the same cycle, gnt moves to 0 next cycle, ptr=0.
  - rst_n pulsed low mid-burst: gnt=0 and sel=0 immediately.
- With MUX4_ARB_LOCK_EN: owner 0 holds lock=1 for 10 beats while req=4'b0011. gnt stays 4'b0001 for all 10 beats, then moves to 1 on req[0] falling.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select pair of a shared 4:1 mux, with a per-grant burst limit.
// Optional MUX4_ARB_LOCK_EN adds a lock input that lets the current owner ignore the burst limit.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data_in,
`ifdef MUX4_ARB_LOCK_EN
    input  logic [3:0]         lock,
`endif
    output logic [3:0]         gnt,
    output logic [1:0]         sel,
    output logic [WIDTH-1:0]   y_data,
    output logic               y_valid,
    input  logic               y_ready,
    output logic               busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t      r_state;
    logic [3:0]  r_gnt;
    logic [1:0]  r_sel;
    logic [1:0]  r_ptr;
    logic [7:0]  r_beatCnt;

    logic        w_accept;
    logic        w_ownerReq;
    logic        w_lockHold;
    logic        w_burstDone;
    logic        w_release;
    logic [1:0]  w_nextPtr;
    logic [3:0]  w_maskedReq;
    logic [2:0]  w_idlePick;
    logic [2:0]  w_relPick;

    // Returns {found, index} of the first asserted request scanning start, start+1, ... mod 4.
    function automatic logic [2:0] pickNext(input logic [3:0] reqs, input logic [1:0] start);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + k[1:0];
            if (reqs[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    assign y_valid    = |(r_gnt & req);
    assign w_accept   = y_valid & y_ready;
    assign w_ownerReq = req[r_sel];

`ifdef MUX4_ARB_LOCK_EN
    assign w_lockHold = lock[r_sel];
`else
    assign w_lockHold = 1'b0;
`endif

    assign w_burstDone = w_accept && !w_lockHold
                         && (({1'b0, r_beatCnt} + 9'd1) >= 9'(MAX_BURST));
    assign w_release   = (r_state == GRANT) && (!w_ownerReq || w_burstDone);
    assign w_nextPtr   = r_sel + 2'd1;
    assign w_maskedReq = req & ~(4'b0001 << r_sel);
    assign w_idlePick  = pickNext(req, r_ptr);
    assign w_relPick   = pickNext(w_maskedReq, w_nextPtr);

    // Arbitration FSM; a release re-arbitrates in the same edge so owners switch without a gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= 4'b0000;
            r_sel     <= 2'd0;
            r_ptr     <= 2'd0;
            r_beatCnt <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_beatCnt <= 8'd0;
                    if (w_idlePick[2]) begin
                        r_state <= GRANT;
                        r_gnt   <= 4'b0001 << w_idlePick[1:0];
                        r_sel   <= w_idlePick[1:0];
                    end else begin
                        r_gnt <= 4'b0000;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr     <= w_nextPtr;
                        r_beatCnt <= 8'd0;
                        if (w_relPick[2]) begin
                            r_gnt <= 4'b0001 << w_relPick[1:0];
                            r_sel <= w_relPick[1:0];
                        end else if (!w_ownerReq) begin
                            r_state <= IDLE;
                            r_gnt   <= 4'b0000;
                        end
                    end else if (w_accept && (r_beatCnt != 8'hFF)) begin
                        r_beatCnt <= r_beatCnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        y_data = data_in[0 +: WIDTH];
        case (r_sel)
            2'd0: y_data = data_in[0*WIDTH +: WIDTH];
            2'd1: y_data = data_in[1*WIDTH +: WIDTH];
            2'd2: y_data = data_in[2*WIDTH +: WIDTH];
            2'd3: y_data = data_in[3*WIDTH +: WIDTH];
            default: y_data = data_in[0 +: WIDTH];
        endcase
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = (r_state == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: a vector table for the single-requester case,
// hand-written sequences for rotation, backpressure, withdrawal and reset, and a beat scoreboard.
module tb_mux4_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         req = 4'b0000;
    logic [4*WIDTH-1:0] data_in;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   y_data;
    logic               y_valid;
    logic               y_ready = 1'b0;
    logic               busy;
`ifdef MUX4_ARB_LOCK_EN
    logic [3:0]         lock = 4'b0000;
`endif

    logic [7:0] slice [4];

    typedef struct packed {
        logic [1:0] owner;
        logic [7:0] data;
    } beat_t;

    typedef struct packed {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       busy;
        logic [7:0] data;
    } vec_t;

    beat_t sb[$];
    vec_t  tbl [8];
    int    nApplied = 0;
    int    nFail = 0;

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data_in (data_in),
`ifdef MUX4_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .sel     (sel),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic pushBeats(input logic [1:0] owner, input int n);
        beat_t b;
        b.owner = owner;
        b.data  = slice[owner];
        for (int i = 0; i < n; i++) begin
            sb.push_back(b);
        end
    endtask

    // Drives one cycle of stimulus on the falling edge; any beat visible now is accepted at the next rise.
    task automatic applyStimulus(input logic [3:0] r, input logic rdy);
        beat_t e;
        @(negedge clk);
        req     = r;
        y_ready = rdy;
        #1;
        if (y_valid && y_ready) begin
            nApplied++;
            if (sb.size() == 0) begin
                nFail++;
                $display("[TB] FAIL sb_extra: unexpected beat gnt=%b data=%h", gnt, y_data);
            end else begin
                e = sb.pop_front();
                if (gnt !== (4'b0001 << e.owner) || y_data !== e.data) begin
                    nFail++;
                    $display("[TB] FAIL sb_beat: got gnt=%b data=%h, want gnt=%b data=%h",
                             gnt, y_data, 4'b0001 << e.owner, e.data);
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] eGnt, input logic [1:0] eSel,
                               input logic eValid, input logic eBusy, input logic [7:0] eData);
        nApplied++;
        if (gnt !== eGnt || sel !== eSel || y_valid !== eValid || busy !== eBusy || y_data !== eData) begin
            nFail++;
            $display("[TB] FAIL %s: got gnt=%b sel=%0d valid=%b busy=%b data=%h, want gnt=%b sel=%0d valid=%b busy=%b data=%h",
                     name, gnt, sel, y_valid, busy, y_data, eGnt, eSel, eValid, eBusy, eData);
        end
    endtask

    task automatic checkEmpty(input string name);
        nApplied++;
        if (sb.size() != 0) begin
            nFail++;
            $display("[TB] FAIL %s: %0d expected beats never accepted, want 0", name, sb.size());
        end
        sb.delete();
    endtask

    // Asserts reset mid-cycle and checks the outputs clear before any clock edge.
    task automatic doReset(input string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput(name, 4'b0000, 2'd0, 1'b0, 1'b0, slice[0]);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        slice[0] = 8'h5A;
        slice[1] = 8'h3C;
        slice[2] = 8'hA5;
        slice[3] = 8'hE7;
        data_in  = {slice[3], slice[2], slice[1], slice[0]};

        tbl[0] = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h5A};
        tbl[1] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5};
        tbl[2] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5};
        tbl[3] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5};
        tbl[4] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5};
        tbl[5] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA5};
        tbl[6] = '{4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 8'hA5};
        tbl[7] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 8'hA5};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset with no requests.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0000, 1'b0);
            checkOutput($sformatf("idle%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0, slice[0]);
        end

        // Single requester 2: grant, burst-limit regrant without gap, withdrawal, sel hold in idle.
        pushBeats(2'd2, 5);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].req, tbl[i].rdy);
            checkOutput($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].busy, tbl[i].data);
        end
        checkEmpty("single_beats");

        // All four requesting from ptr=0: rotation 0,1,2,3,0 with four beats each.
        doReset("rst_before_rot");
        pushBeats(2'd0, 4);
        pushBeats(2'd1, 4);
        pushBeats(2'd2, 4);
        pushBeats(2'd3, 4);
        pushBeats(2'd0, 4);
        for (int c = 0; c <= 20; c++) begin
            applyStimulus(4'b1111, 1'b1);
            if (c == 0) checkOutput("rot_idle", 4'b0000, 2'd0, 1'b0, 1'b0, slice[0]);
            if (c == 5) checkOutput("rot_sw1", 4'b0010, 2'd1, 1'b1, 1'b1, slice[1]);
        end
        checkEmpty("rot_beats");
        applyStimulus(4'b0000, 1'b1);
        checkOutput("rot_next", 4'b0010, 2'd1, 1'b0, 1'b1, slice[1]);

        // Backpressure on owner 1 (ptr=2): stall five cycles mid-burst, still exactly four beats.
        pushBeats(2'd1, 4);
        pushBeats(2'd0, 1);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("bp_idle", 4'b0000, 2'd1, 1'b0, 1'b0, slice[1]);
        applyStimulus(4'b0011, 1'b1);
        applyStimulus(4'b0011, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0011, 1'b0);
            checkOutput($sformatf("bp_stall%0d", i), 4'b0010, 2'd1, 1'b1, 1'b1, slice[1]);
        end
        applyStimulus(4'b0011, 1'b1);
        applyStimulus(4'b0011, 1'b1);
        applyStimulus(4'b0011, 1'b1);
        checkOutput("bp_switch", 4'b0001, 2'd0, 1'b1, 1'b1, slice[0]);
        applyStimulus(4'b0000, 1'b1);
        checkEmpty("bp_beats");
        applyStimulus(4'b0000, 1'b1);
        checkOutput("bp_done", 4'b0000, 2'd0, 1'b0, 1'b0, slice[0]);

        // Withdrawal: owner 3 (ptr=1) drops req after two beats, grant passes to 0.
        pushBeats(2'd3, 2);
        pushBeats(2'd0, 1);
        applyStimulus(4'b1001, 1'b1);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("wd_own3", 4'b1000, 2'd3, 1'b1, 1'b1, slice[3]);
        applyStimulus(4'b1001, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("wd_drop", 4'b1000, 2'd3, 1'b0, 1'b1, slice[3]);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("wd_to0", 4'b0001, 2'd0, 1'b1, 1'b1, slice[0]);
        applyStimulus(4'b0000, 1'b1);
        checkEmpty("wd_beats");

        // Reset pulsed mid-burst while owner 2 holds the channel.
        pushBeats(2'd2, 2);
        applyStimulus(4'b0100, 1'b1);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("rst_own2", 4'b0100, 2'd2, 1'b1, 1'b1, slice[2]);
        applyStimulus(4'b0100, 1'b1);
        req = 4'b0100;
        doReset("rst_mid_burst");
        checkEmpty("rst_beats");
        applyStimulus(4'b0000, 1'b1);
        checkOutput("rst_after", 4'b0000, 2'd0, 1'b0, 1'b0, slice[0]);

`ifdef MUX4_ARB_LOCK_EN
        // Owner 0 locked for ten beats against a waiting requester 1.
        lock = 4'b0001;
        pushBeats(2'd0, 10);
        pushBeats(2'd1, 1);
        applyStimulus(4'b0011, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0011, 1'b1);
            checkOutput($sformatf("lock%0d", i), 4'b0001, 2'd0, 1'b1, 1'b1, slice[0]);
        end
        applyStimulus(4'b0010, 1'b1);
        checkOutput("lock_drop", 4'b0001, 2'd0, 1'b0, 1'b1, slice[0]);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("lock_to1", 4'b0010, 2'd1, 1'b1, 1'b1, slice[1]);
        lock = 4'b0000;
        applyStimulus(4'b0000, 1'b1);
        checkEmpty("lock_beats");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
        $finish;
    end

endmodule
